pipe_hazard_ctrl: RTL and testbench

- Hazard, stall and forwarding controller for the 5-stage RV32 pipeline.
- Watches the ID, EX, MEM and WB pipeline registers, including the MEM/WB writeback register carrying rf_wen, wb_Sel, mem_val and BE_rdy.
- Drives forwarding muxes, per-stage stall enables and flush/bubble controls.
- Sequences multi-cycle data-memory waits, with a timeout watchdog.

---
 rtl/pipe_hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard/stall/forwarding control for a 5-stage RV32 pipeline; HAZARD_PERF_EN adds stall/flush counters
module pipe_hazard_ctrl #(
  parameter logic [1:0] WB_MEM      = 2'd1,
  parameter int         MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_rf_wen,
  input  logic [1:0] ex_wb_sel,
  input  logic       ex_branch_taken,
  input  logic [4:0] mem_rd,
  input  logic       mem_rf_wen,
  input  logic [1:0] mem_val,
  input  logic       BE_rdy,
  input  logic [4:0] wb_rd,
  input  logic       wb_rf_wen,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       stall_if,
  output logic       stall_id,
  output logic       stall_ex,
  output logic       hold_mem,
  output logic       flush_if_id,
  output logic       bubble_ex,
`ifdef HAZARD_PERF_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
`endif
  output logic       mem_err
);
  typedef enum logic [1:0] {RUN, LOAD_USE, MEM_WAIT} state_t;
  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       redirect_pend_q, redirect_pend_d;
  logic       mem_err_q, mem_err_d;
  logic       mem_busy, load_use, timeout, hold, lu_stall;
  assign mem_busy = (mem_val != 2'b00) && !BE_rdy;
  assign load_use = ex_rf_wen && ex_wb_sel == WB_MEM && ex_rd != 5'd0 &&
                    ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  assign timeout  = wait_cnt_q == 8'(MEM_TIMEOUT);
  assign mem_err  = mem_err_q;
  // state register plus wait counter, pending redirect and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= RUN;
      wait_cnt_q      <= 8'd0;
      redirect_pend_q <= 1'b0;
      mem_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      wait_cnt_q      <= wait_cnt_d;
      redirect_pend_q <= redirect_pend_d;
      mem_err_q       <= mem_err_d;
    end
  end
  // next state: a busy memory preempts everything; a wait ends on ack or timeout
  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    redirect_pend_d = redirect_pend_q;
    mem_err_d       = mem_err_q;
    if (state_q == MEM_WAIT) begin
      if (!mem_busy || timeout) begin
        state_d         = RUN;
        wait_cnt_d      = 8'd0;
        redirect_pend_d = 1'b0;
        mem_err_d       = mem_err_q | mem_busy;
      end else begin
        wait_cnt_d = wait_cnt_q == 8'hFF ? wait_cnt_q : wait_cnt_q + 8'd1;
      end
    end else if (mem_busy) begin
      state_d         = MEM_WAIT;
      wait_cnt_d      = 8'd1;
      redirect_pend_d = state_q == RUN && ex_branch_taken;
    end else begin
      state_d = state_q == RUN && !ex_branch_taken && load_use ? LOAD_USE : RUN;
    end
  end
  // control outputs are combinational so they act in the same cycle; reset forces a flush
  always_comb begin
    hold        = state_q == MEM_WAIT ? mem_busy && !timeout : mem_busy;
    lu_stall    = state_q == RUN && !mem_busy && !ex_branch_taken && load_use;
    flush_if_id = state_q == RUN ? !mem_busy && ex_branch_taken :
                  state_q == MEM_WAIT ? redirect_pend_q && (!mem_busy || timeout) : 1'b0;
    bubble_ex   = flush_if_id || lu_stall;
    stall_if    = hold || lu_stall;
    stall_id    = hold || lu_stall;
    stall_ex    = hold;
    hold_mem    = hold;
    fwd_a_sel   = (id_use_rs1 && mem_rf_wen && mem_rd != 5'd0 && mem_rd == id_rs1) ? 2'b01 :
                  (id_use_rs1 && wb_rf_wen && wb_rd != 5'd0 && wb_rd == id_rs1) ? 2'b10 : 2'b00;
    fwd_b_sel   = (id_use_rs2 && mem_rf_wen && mem_rd != 5'd0 && mem_rd == id_rs2) ? 2'b01 :
                  (id_use_rs2 && wb_rf_wen && wb_rd != 5'd0 && wb_rd == id_rs2) ? 2'b10 : 2'b00;
    if (reset) begin
      stall_if    = 1'b0;
      stall_id    = 1'b0;
      stall_ex    = 1'b0;
      hold_mem    = 1'b0;
      fwd_a_sel   = 2'b00;
      fwd_b_sel   = 2'b00;
      flush_if_id = 1'b1;
      bubble_ex   = 1'b1;
    end
  end
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q, flush_count_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
  // free-running wrap-around counters of stalled and flushed cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_q + 32'(stall_if);
      flush_count_q  <= flush_count_q + 32'(flush_if_id);
    end
  end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for pipe_hazard_ctrl with directed vectors
module tb_pipe_hazard_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs1, id_use_rs2, ex_rf_wen, ex_branch_taken, mem_rf_wen, BE_rdy, wb_rf_wen;
  logic [1:0] ex_wb_sel, mem_val;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall_if, stall_id, stall_ex, hold_mem, flush_if_id, bubble_ex, mem_err;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif
  always #5 clk = ~clk;
  pipe_hazard_ctrl #(.WB_MEM(2'd1), .MEM_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_rf_wen(ex_rf_wen), .ex_wb_sel(ex_wb_sel), .ex_branch_taken(ex_branch_taken),
    .mem_rd(mem_rd), .mem_rf_wen(mem_rf_wen), .mem_val(mem_val), .BE_rdy(BE_rdy),
    .wb_rd(wb_rd), .wb_rf_wen(wb_rf_wen),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .hold_mem(hold_mem),
    .flush_if_id(flush_if_id), .bubble_ex(bubble_ex),
`ifdef HAZARD_PERF_EN
    .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
    .mem_err(mem_err)
  );
  // expected vector: {fwd_a[1:0], fwd_b[1:0], stall_if, stall_id, stall_ex, hold_mem, flush, bubble, mem_err}
  localparam logic [10:0] IDLE = 11'b00_00_0000_00_0;
  localparam logic [10:0] HOLD = 11'b00_00_1111_00_0;
  localparam logic [10:0] FLB  = 11'b00_00_0000_11_0;
  localparam logic [10:0] LU   = 11'b00_00_1100_01_0;
  localparam logic [10:0] ERR  = 11'b00_00_0000_00_1;
  localparam logic [10:0] FA01 = 11'b01_00_0000_00_0;
  localparam logic [10:0] FB01 = 11'b00_01_0000_00_0;
  localparam logic [10:0] FB10 = 11'b00_10_0000_00_0;
  typedef struct {
    string       name;
    logic [10:0] exp;
    logic        rst;
    logic [31:0] sc;
    logic [31:0] fc;
  } item_t;
  item_t       sb[$];
  item_t       it;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] sc_m = 0, fc_m = 0;
  logic [10:0] act;
  assign act = {fwd_a_sel, fwd_b_sel, stall_if, stall_id, stall_ex, hold_mem, flush_if_id, bubble_ex, mem_err};
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      it = sb.pop_front();
      checks++;
      if (act !== it.exp) begin
        errors++;
        $display("FAIL %s: got %b expected %b", it.name, act, it.exp);
      end
`ifdef HAZARD_PERF_EN
      if (!it.rst) begin
        checks++;
        if (stall_cycles !== it.sc || flush_count !== it.fc) begin
          errors++;
          $display("FAIL %s_perf: got sc=%0d fc=%0d expected sc=%0d fc=%0d", it.name, stall_cycles, flush_count, it.sc, it.fc);
        end
      end
`endif
    end
  end
  task automatic step(input logic [10:0] e, input string n);
    sb.push_back('{n, e, reset, sc_m, fc_m});
    if (reset) begin
      sc_m = 0;
      fc_m = 0;
    end else begin
      sc_m += 32'(e[6]);
      fc_m += 32'(e[2]);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    {id_rs1, id_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_use_rs1, id_use_rs2, ex_rf_wen, ex_branch_taken, mem_rf_wen, BE_rdy, wb_rf_wen} = '0;
    ex_wb_sel = 2'd0;
    mem_val   = 2'd0;
  endtask
  initial begin
    clr();
    reset = 1'b1;
    @(posedge clk);
    #1;
    step(FLB, "reset");
    reset = 1'b0;
    step(IDLE, "idle");
    ex_rf_wen = 1; ex_wb_sel = 2'd1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    step(LU, "lu_stall");
    ex_rf_wen = 0; ex_wb_sel = 0; ex_rd = 0; mem_rd = 5; mem_rf_wen = 1;
    step(FA01, "lu_fwd");
    clr();
    mem_rd = 3; wb_rd = 3; mem_rf_wen = 1; wb_rf_wen = 1; id_rs2 = 3; id_use_rs2 = 1;
    step(FB01, "fwd_mem_prio");
    mem_rd = 0; wb_rd = 0; id_rs2 = 0;
    step(IDLE, "fwd_x0");
    wb_rd = 3; id_rs2 = 3; mem_rf_wen = 0;
    step(FB10, "fwd_wb");
    id_use_rs2 = 0;
    step(IDLE, "fwd_unused");
    clr();
    mem_val = 2'b01;
    for (int i = 0; i < 4; i++) step(HOLD, "mem_wait");
    BE_rdy = 1;
    step(IDLE, "mem_release");
    clr();
    ex_branch_taken = 1;
    step(FLB, "back_run");
    mem_val = 2'b01;
    for (int i = 0; i < 3; i++) step(HOLD, "br_wait");
    ex_branch_taken = 0; BE_rdy = 1;
    step(FLB, "redirect");
    clr();
    step(IDLE, "after_redirect");
    mem_val = 2'b01;
    for (int i = 0; i < 8; i++) step(HOLD, "to_wait");
    step(IDLE, "to_release");
    mem_val = 0;
    step(ERR, "to_err");
    step(ERR, "err_sticky");
    reset = 1;
    step(FLB | ERR, "err_in_reset");
    reset = 0;
    step(IDLE, "err_cleared");
    mem_val = 2'b01;
    step(HOLD, "rst_wait0");
    step(HOLD, "rst_wait1");
    reset = 1;
    step(FLB, "rst_mid_wait");
    reset = 0; mem_val = 0;
    step(IDLE, "post_reset");
    for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
